// File: rtl/frame_sequencer.sv
// Frame sequencer: latches view parameters, resets and waits on the solver array,
// then streams its pixels in raster order. Optional solve watchdog: FRAME_TIMEOUT_EN.
module frame_sequencer #(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480
`ifdef FRAME_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [26:0] cfg_min_x,
  input  logic signed [26:0] cfg_min_y,
  input  logic signed [26:0] cfg_dx,
  input  logic signed [26:0] cfg_dy,
  input  logic [9:0]         cfg_iterations,
  output logic               busy,
  output logic               solver_reset,
  output logic signed [26:0] min_x,
  output logic signed [26:0] min_y,
  output logic signed [26:0] dx,
  output logic signed [26:0] dy,
  output logic [9:0]         iterations,
  input  logic               solver_done,
  output logic [5:0]         rd_solver_id,
  output logic [18:0]        rd_addr,
  input  logic [3:0]         rd_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [3:0]         pix_data,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic [15:0]        frame_count
`ifdef FRAME_TIMEOUT_EN
  ,output logic              timeout
`endif
);

  localparam int SID_W     = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int COL_W     = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int LAST_PIX  = NUM_COLUMNS * NUM_ROWS - 1;
  localparam int LAST_SID  = LAST_PIX % NUM_SOLVERS;
  localparam int LAST_ADDR = LAST_PIX / NUM_SOLVERS;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SOLVE, S_STREAM} state_t;

  state_t             state_reg, state_next;
  logic               clear_cnt_reg;
  logic               solve_armed_reg;
  logic               pending_reg;
  logic [15:0]        frame_count_reg;
  logic signed [26:0] min_x_reg, min_y_reg, dx_reg, dy_reg;
  logic [9:0]         iterations_reg;

  logic [SID_W-1:0]   sid_reg;
  logic [18:0]        addr_reg;
  logic [COL_W-1:0]   col_reg;
  logic               iss_done_reg;
  logic               inflight_reg;
  logic [2:0]         meta_reg;

  // FIFO entry layout: {last, sof, eol, data[3:0]}
  logic [6:0]         fifo_mem [2];
  logic               wr_ptr_reg, rd_ptr_reg;
  logic [1:0]         occ_reg;
  logic [6:0]         head;
  logic               head_last;

  logic               pop, issue, iss_last, stream_end, solve_exit, abort, load_params;

  assign head       = fifo_mem[rd_ptr_reg];
  assign head_last  = head[6];
  assign pix_valid  = (occ_reg != 2'd0);
  assign pix_sof    = head[5];
  assign pix_eol    = head[4];
  assign pix_data   = head[3:0];

  assign pop        = pix_valid && pix_ready;
  assign stream_end = pop && head_last;
  assign solve_exit = (state_reg == S_SOLVE) && solve_armed_reg && solver_done;
  assign iss_last   = (sid_reg == SID_W'(LAST_SID)) && (addr_reg == 19'(LAST_ADDR));

  // A slot freed by this cycle's pop can be refilled at once, giving 1 pixel/cycle.
  assign issue = (state_reg == S_STREAM) && !iss_done_reg &&
                 (({1'b0, occ_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

  // Parameters are only ever captured on the way into CLEAR.
  assign load_params = (state_next == S_CLEAR) && (state_reg != S_CLEAR);

`ifdef FRAME_TIMEOUT_EN
  logic [31:0] to_cnt_reg;
  logic        timeout_reg;

  assign abort   = (state_reg == S_SOLVE) && !solve_exit &&
                   (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == S_SOLVE) ? to_cnt_reg + 32'd1 : 32'd0;
      if (abort)
        timeout_reg <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (start) state_next = S_CLEAR;
      S_CLEAR:  if (clear_cnt_reg) state_next = S_SOLVE;
      S_SOLVE: begin
        if (solve_exit)
          state_next = S_STREAM;
        else if (abort)
          state_next = (pending_reg || start) ? S_CLEAR : S_IDLE;
      end
      S_STREAM: if (stream_end) state_next = (pending_reg || start) ? S_CLEAR : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_reg != S_IDLE);
    solver_reset = (state_reg == S_IDLE) || (state_reg == S_CLEAR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clear_cnt_reg   <= 1'b0;
      solve_armed_reg <= 1'b0;
      pending_reg     <= 1'b0;
      frame_count_reg <= '0;
      min_x_reg       <= '0;
      min_y_reg       <= '0;
      dx_reg          <= '0;
      dy_reg          <= '0;
      iterations_reg  <= '0;
    end else begin
      clear_cnt_reg   <= (state_reg == S_CLEAR) && !clear_cnt_reg;
      solve_armed_reg <= (state_reg == S_SOLVE);
      frame_count_reg <= frame_count_reg + 16'(stream_end);
      if (load_params)
        pending_reg <= 1'b0;
      else if (start && (state_reg != S_IDLE))
        pending_reg <= 1'b1;
      if (load_params) begin
        min_x_reg      <= cfg_min_x;
        min_y_reg      <= cfg_min_y;
        dx_reg         <= cfg_dx;
        dy_reg         <= cfg_dy;
        iterations_reg <= cfg_iterations;
      end
    end
  end

  // Read side: solver id cycles fastest, address advances on each wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sid_reg      <= '0;
      addr_reg     <= '0;
      col_reg      <= '0;
      iss_done_reg <= 1'b0;
      inflight_reg <= 1'b0;
      meta_reg     <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue)
        meta_reg <= {iss_last,
                     (sid_reg == '0) && (addr_reg == '0),
                     (col_reg == COL_W'(NUM_COLUMNS - 1))};
      if (state_reg != S_STREAM) begin
        sid_reg      <= '0;
        addr_reg     <= '0;
        col_reg      <= '0;
        iss_done_reg <= 1'b0;
      end else if (issue) begin
        if (sid_reg == SID_W'(NUM_SOLVERS - 1)) begin
          sid_reg  <= '0;
          addr_reg <= addr_reg + 19'd1;
        end else begin
          sid_reg <= sid_reg + SID_W'(1);
        end
        col_reg <= (col_reg == COL_W'(NUM_COLUMNS - 1)) ? '0 : col_reg + COL_W'(1);
        if (iss_last)
          iss_done_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++)
        fifo_mem[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= '0;
    end else begin
      if (inflight_reg) begin
        fifo_mem[wr_ptr_reg] <= {meta_reg, rd_data};
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  assign rd_solver_id = 6'(sid_reg);
  assign rd_addr      = addr_reg;
  assign min_x        = min_x_reg;
  assign min_y        = min_y_reg;
  assign dx           = dx_reg;
  assign dy           = dy_reg;
  assign iterations   = iterations_reg;
  assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: 2 solvers, 4x2 frame, RAM model with fixed pixel table.
module tb_frame_sequencer;
  localparam int NS = 2;
  localparam int NC = 4;
  localparam int NR = 2;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic signed [26:0] cfg_min_x = '0, cfg_min_y = '0, cfg_dx = '0, cfg_dy = '0;
  logic [9:0]         cfg_iterations = '0;
  logic               busy, solver_reset;
  logic signed [26:0] min_x, min_y, dx, dy;
  logic [9:0]         iterations;
  logic               solver_done = 1'b0;
  logic [5:0]         rd_solver_id;
  logic [18:0]        rd_addr;
  logic [3:0]         rd_data;
  logic               pix_valid, pix_sof, pix_eol;
  logic               pix_ready = 1'b0;
  logic [3:0]         pix_data;
  logic [15:0]        frame_count;
`ifdef FRAME_TIMEOUT_EN
  logic               timeout;
`endif

  int checks = 0;
  int errors = 0;
  int first_cyc, last_cyc;
  logic [3:0] px [8] = '{4'h1, 4'hA, 4'h3, 4'hC, 4'h5, 4'hE, 4'h7, 4'hF};

  frame_sequencer #(
    .NUM_SOLVERS(NS), .NUM_COLUMNS(NC), .NUM_ROWS(NR)
`ifdef FRAME_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cfg_min_x(cfg_min_x), .cfg_min_y(cfg_min_y), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .cfg_iterations(cfg_iterations),
    .busy(busy), .solver_reset(solver_reset),
    .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy), .iterations(iterations),
    .solver_done(solver_done), .rd_solver_id(rd_solver_id), .rd_addr(rd_addr),
    .rd_data(rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_count(frame_count)
`ifdef FRAME_TIMEOUT_EN
    ,.timeout(timeout)
`endif
  );

  always #5 clock = ~clock;

  // Solver array model: pixel p = addr*2 + sid lives at px[p], one-cycle read latency.
  always @(posedge clock) rd_data <= px[{rd_addr[1:0], rd_solver_id[0]}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From IDLE: start, two CLEAR cycles, done raised in second SOLVE cycle; ends at STREAM cycle 0.
  task automatic start_and_solve(input logic signed [26:0] mx);
    cfg_min_x = mx;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    solver_done = 1'b1; step(); solver_done = 1'b0;
  endtask

  // Consumes one full frame with the given ready pattern, checking every visible pixel.
  task automatic stream_frame(input logic [15:0] pat, output int fc, output int lc);
    int idx;
    int cyc;
    logic held;
    idx = 0; cyc = 0; held = 1'b0; fc = -1; lc = -1;
    while (idx < NC * NR && cyc < 200) begin
      pix_ready = pat[cyc % 16];
      if (held)
        check("stall_valid_held", 32'(pix_valid), 1);
      if (pix_valid) begin
        check("pix_data", 32'(pix_data), 32'(px[idx]));
        check("pix_sof", 32'(pix_sof), (idx == 0) ? 1 : 0);
        check("pix_eol", 32'(pix_eol), (idx % NC == NC - 1) ? 1 : 0);
      end
      if (pix_valid && pix_ready) begin
        if (idx == 0) fc = cyc;
        lc = cyc;
        idx++;
      end
      held = pix_valid && !pix_ready;
      step();
      cyc++;
    end
    check("pixel_count", 32'(idx), NC * NR);
    pix_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_solver_reset", 32'(solver_reset), 1);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_min_x", 32'(min_x), 0);
    check("rst_iterations", 32'(iterations), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
`ifdef FRAME_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 0);
`endif
    reset_n = 1'b1; step();
    check("idle_solver_reset", 32'(solver_reset), 1);

    // Frame 1: basic sequencing, latency, throughput
    cfg_min_x = 27'h055; cfg_min_y = 27'h0AA; cfg_dx = 27'h003; cfg_dy = 27'h004;
    cfg_iterations = 10'd100;
    start = 1'b1; step(); start = 1'b0;
    check("clear1_busy", 32'(busy), 1);
    check("clear1_solver_reset", 32'(solver_reset), 1);
    check("latch_min_x", 32'(min_x), 32'h055);
    check("latch_min_y", 32'(min_y), 32'h0AA);
    check("latch_dx", 32'(dx), 32'h003);
    check("latch_dy", 32'(dy), 32'h004);
    check("latch_iterations", 32'(iterations), 100);
    cfg_min_x = 27'h777;
    step();
    check("clear2_solver_reset", 32'(solver_reset), 1);
    step();
    check("solve_solver_reset", 32'(solver_reset), 0);
    check("solve_min_x_frozen", 32'(min_x), 32'h055);
    solver_done = 1'b1; step(); solver_done = 1'b0;
    step(); step();
    check("first_done_ignored_valid", 32'(pix_valid), 0);
    check("first_done_ignored_addr", 32'(rd_addr), 0);
    check("first_done_ignored_busy", 32'(busy), 1);
    solver_done = 1'b1; step(); solver_done = 1'b0;
    check("stream_rd_sid0", 32'(rd_solver_id), 0);
    check("stream_rd_addr0", 32'(rd_addr), 0);
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("initial_latency", 32'(first_cyc), 2);
    check("full_rate_last", 32'(last_cyc), 9);
    check("f1_busy_drop", 32'(busy), 0);
    check("f1_frame_count", 32'(frame_count), 1);
    check("f1_pix_valid", 32'(pix_valid), 0);

    // Frame 2: stalled start, then irregular ready
    start_and_solve(27'h055);
    pix_ready = 1'b0;
    repeat (5) step();
    check("stall_pix_valid", 32'(pix_valid), 1);
    check("stall_pix_data", 32'(pix_data), 32'(px[0]));
    check("stall_pix_sof", 32'(pix_sof), 1);
    check("stall_two_reads_sid", 32'(rd_solver_id), 0);
    check("stall_two_reads_addr", 32'(rd_addr), 1);
    stream_frame(16'b1010_0110_0011_0101, first_cyc, last_cyc);
    check("f2_frame_count", 32'(frame_count), 2);
    check("f2_busy", 32'(busy), 0);

    // Frame 3: start during STREAM queues a frame with new min_x
    start_and_solve(27'h055);
    pix_ready = 1'b0;
    step(); step();
    cfg_min_x = 27'h100;
    start = 1'b1; step(); start = 1'b0;
    check("pending_min_x_frozen", 32'(min_x), 32'h055);
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("f3_frame_count", 32'(frame_count), 3);
    check("f3_back_to_back_busy", 32'(busy), 1);
    check("f3_clear1_solver_reset", 32'(solver_reset), 1);
    check("f3_relatch_min_x", 32'(min_x), 32'h100);
    step();
    check("f3_clear2_solver_reset", 32'(solver_reset), 1);
    step();
    check("f4_solve_solver_reset", 32'(solver_reset), 0);
    check("f4_solve_min_x", 32'(min_x), 32'h100);
    step();
    solver_done = 1'b1; step(); solver_done = 1'b0;
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("f4_frame_count", 32'(frame_count), 4);
    check("f4_busy", 32'(busy), 0);

    // Frame 5: three starts during SOLVE merge into one extra frame
    cfg_min_x = 27'h055;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    step();
    start = 1'b1; step();
    step(); start = 1'b0;
    solver_done = 1'b1; step(); solver_done = 1'b0;
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("f5_frame_count", 32'(frame_count), 5);
    check("f5_extra_frame_busy", 32'(busy), 1);
    step(); step(); step();
    solver_done = 1'b1; step(); solver_done = 1'b0;
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("f6_frame_count", 32'(frame_count), 6);
    check("f6_only_one_extra", 32'(busy), 0);
    step(); step();
    check("f6_stays_idle", 32'(busy), 0);

    // Reset asserted mid-stream at pixel 3
    start_and_solve(27'h055);
    pix_ready = 1'b1;
    repeat (5) step();
    check("pre_reset_valid", 32'(pix_valid), 1);
    check("pre_reset_pixel3", 32'(pix_data), 32'(px[3]));
    reset_n = 1'b0;
    #1;
    check("async_rst_pix_valid", 32'(pix_valid), 0);
    check("async_rst_solver_reset", 32'(solver_reset), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_frame_count", 32'(frame_count), 0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_pix_valid", 32'(pix_valid), 0);
    start_and_solve(27'h055);
    stream_frame(16'hFFFF, first_cyc, last_cyc);
    check("post_rst_frame_count", 32'(frame_count), 1);

`ifdef FRAME_TIMEOUT_EN
    // Watchdog: solver_done never arrives
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    repeat (19) step();
    check("to_before_busy", 32'(busy), 1);
    check("to_before_flag", 32'(timeout), 0);
    step();
    check("to_idle", 32'(busy), 0);
    check("to_flag", 32'(timeout), 1);
    check("to_frame_count", 32'(frame_count), 1);
    check("to_no_pixels", 32'(pix_valid), 0);
    step();
    check("to_sticky", 32'(timeout), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sequences one fractal frame end to end through the multi-solver array:
  - latches view parameters;
  - pulses the solver reset;
  - waits for all solvers to finish;
  - streams the stored pixels out in raster order over a valid/ready interface.
- Sits between the host/config logic and the multi-solver block.
- Drives the array's reset, parameter and read ports.
- Feeds the pixel stream to the display/framebuffer writer.
- Single clock domain; the array's read clock is tied to the same clock.

Parameters:
- NUM_SOLVERS, 1, number of interleaved solvers; pixel p belongs to solver p mod NUM_SOLVERS, at address p div NUM_SOLVERS.
- NUM_COLUMNS, 640, pixels per row.
- NUM_ROWS, 480, rows per frame.
- TIMEOUT_CYCLES, 50000000, solve watchdog limit; used only with FRAME_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a frame with the current cfg_* values.
- cfg_min_x, cfg_min_y, cfg_dx, cfg_dy  in  27 each  signed view parameters.
- cfg_iterations  in  10  iteration limit.
- busy  out  1  high in any state other than IDLE.
- solver_reset  out  1  active-high reset to the array.
- min_x, min_y, dx, dy  out  27 each  latched parameters to the array.
- iterations  out  10  latched iteration limit to the array.
- solver_done  in  1  array done.
- rd_solver_id  out  6  array read select.
- rd_addr  out  19  array read address.
- rd_data  in  4  array read data; valid 1 cycle after address.
- pix_valid  out  1  pixel stream valid.
- pix_ready  in  1  downstream ready.
- pix_data  out  4  pixel value.
- pix_sof  out  1  first pixel of frame.
- pix_eol  out  1  last pixel of a row.
- frame_count  out  16  completed frames, wraps.
- timeout  out  1  sticky watchdog flag; exists only with FRAME_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all outputs 0 except solver_reset=1.
  - Latched parameters 0; pixel counters 0; pending flag 0.
- IDLE:
  - solver_reset held 1.
  - start=1: latch cfg_* into the parameter outputs, go to CLEAR.
- CLEAR:
  - solver_reset=1 for exactly 2 cycles, then SOLVE.
- SOLVE:
  - solver_reset=0.
  - solver_done is ignored in the first SOLVE cycle.
  - From the second cycle, solver_done=1 moves to STREAM next cycle.
- STREAM:
  - Pixel index p runs 0..NUM_COLUMNS*NUM_ROWS-1.
  - Counters sid (0..NUM_SOLVERS-1) and addr; no divider.
    - On each issued read, sid increments.
    - When sid wraps to 0, addr increments.
  - rd_solver_id=sid, rd_addr=addr.
  - Reads go into a 2-entry output FIFO:
    - a read issues only when (FIFO occupancy + reads in flight) < 2;
    - 1-cycle latency; returned data is written into the FIFO.
  - A pixel transfers when pix_valid && pix_ready.
  - pix_data/pix_sof/pix_eol must be held stable while pix_valid && !pix_ready.
  - pix_sof=1 on p=0; pix_eol=1 when p mod NUM_COLUMNS = NUM_COLUMNS-1.
  - Sustained pix_ready=1 gives 1 pixel/cycle after a 2-cycle initial latency.
  - After the last pixel transfers: frame_count++; go to IDLE, or to CLEAR if pending.
- start outside IDLE:
  - sets pending (one deep; further starts merge);
  - cfg_* is re-latched at the moment pending is consumed, not when start arrives.
  - Latched parameters never change during CLEAR, SOLVE or STREAM.
- Simultaneous stream end and start: start sets pending, and the next state is CLEAR.
- reset_n asserted mid-operation:
  - immediate return to IDLE; pending cleared; FIFO flushed; pix_valid=0 asynchronously.
- Widths:
  - addr and sid compare against parameter-derived constants;
  - rd_solver_id is zero-extended to 6 bits.

Optional Feature:
- Macro FRAME_TIMEOUT_EN.
- Defined:
  - a 32-bit counter runs in SOLVE;
  - reaching TIMEOUT_CYCLES without solver_done sets timeout=1 (sticky until reset_n) and returns to IDLE;
  - no stream; frame_count unchanged; pending preserved (an abort with pending set goes to CLEAR).
- Undefined:
  - no counter and no timeout port; SOLVE waits indefinitely.

Test Plan:
- NUM_SOLVERS=2, 4x2 frame, pix_ready=1, solver_done 5 cycles after CLEAR:
  - rd sequence (sid,addr) = (0,0)(1,0)(0,1)(1,1)(0,2)(1,2)(0,3)(1,3);
  - pix_data matches the RAM model;
  - sof on pixel 0, eol on pixels 3 and 7;
  - frame_count=1, busy drops.
- Same frame, pix_ready toggled randomly:
  - no pixel lost or duplicated;
  - outputs held stable while stalled;
  - never more than 2 reads outstanding.
- start pulsed during STREAM with new cfg_min_x=27'h100:
  - the current frame completes with the old parameters;
  - CLEAR follows immediately (2 cycles of solver_reset);
  - min_x=27'h100 during the second SOLVE; frame_count=2.
- Three starts during SOLVE: exactly one extra frame runs.
- reset_n low during STREAM at pixel 3:
  - pix_valid=0 and solver_reset=1 in the same cycle;
  - after release, state is IDLE and the next start streams from pixel 0 with sof.
- FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=20 and solver_done never asserted:
  - timeout=1 after 20 SOLVE cycles; state IDLE; frame_count=0; no pix_valid.
